// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Round-robin share of one external memory port between the
//             instruction-fetch refill path and the load/store unit, with
//             an in-order outstanding-read FIFO for response routing and
//             local execution of LS fences by draining outstanding reads.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 16,
    parameter int TAG_W     = 4,
    parameter int MAX_OUTST = 4
) (
    input  logic              clk,
    input  logic              sync_rst,
    input  logic              clk_en,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              ls_req_valid,
    input  logic [1:0]        ls_req_mode,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic [1:0]        ls_req_mask,
    input  logic [DATA_W-1:0] ls_req_data,
    input  logic [TAG_W-1:0]  ls_req_tag,
    output logic              ls_req_ready,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rsp_data,
    output logic [TAG_W-1:0]  ls_rsp_tag,
    output logic              ls_fence_done,
    output logic              bus_req_valid,
    output logic              bus_req_write,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic [1:0]        bus_req_mask,
    output logic [DATA_W-1:0] bus_req_data,
    input  logic              bus_req_ready,
    input  logic              bus_rsp_valid,
    input  logic [DATA_W-1:0] bus_rsp_data,
    output logic              idle,
    output logic              err
);

    localparam int                 c_PTR_W      = $clog2(MAX_OUTST);
    localparam int                 c_CNT_W      = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_FULL   = c_CNT_W'(MAX_OUTST);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO   = '0;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE    = c_PTR_W'(1);
    localparam logic [1:0]         c_MODE_READ  = 2'd0;
    localparam logic [1:0]         c_MODE_WRITE = 2'd1;
    localparam logic               c_SRC_IF     = 1'b0;
    localparam logic               c_SRC_LS     = 1'b1;

    typedef enum logic [1:0] {
        S_ARB   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_prio;            // c_SRC_IF or c_SRC_LS holds priority
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic               r_fifo_src [MAX_OUTST];
    logic [TAG_W-1:0]   r_fifo_tag [MAX_OUTST];

    logic w_full;
    logic w_empty;
    logic w_if_elig;
    logic w_ls_elig;
    logic w_if_win;
    logic w_ls_win;
    logic w_push;
    logic w_pop;
    logic w_stray;
    logic w_head_src;

    assign w_full     = (r_count == c_CNT_FULL);
    assign w_empty    = (r_count == c_CNT_ZERO);
    assign w_head_src = r_fifo_src[r_rd_ptr];
    // Eligibility looks only at registered occupancy, so a pop this cycle
    // cannot open a slot for a grant in the same cycle.
    assign w_push     = if_req_ready || (ls_req_ready && (ls_req_mode == c_MODE_READ));
    assign w_pop      = bus_rsp_valid && !w_empty;
    assign w_stray    = bus_rsp_valid && w_empty;

    assign idle          = (r_state == S_ARB) && w_empty;
    assign ls_fence_done = (r_state == S_DONE);

    // Arbitration, bus request mux, readies and FSM next state.
    always_comb begin
        w_state_nxt   = r_state;
        w_if_elig     = 1'b0;
        w_ls_elig     = 1'b0;
        w_if_win      = 1'b0;
        w_ls_win      = 1'b0;
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        bus_req_valid = 1'b0;
        bus_req_write = 1'b0;
        bus_req_addr  = '0;
        bus_req_mask  = 2'b00;
        bus_req_data  = '0;
        case (r_state)
            S_ARB: begin
                w_if_elig = if_req_valid && !w_full;
                w_ls_elig = ls_req_valid && ((ls_req_mode != c_MODE_READ) || !w_full);
                if (w_if_elig && w_ls_elig) begin
                    w_if_win = (r_prio == c_SRC_IF);
                    w_ls_win = (r_prio == c_SRC_LS);
                end else begin
                    w_if_win = w_if_elig;
                    w_ls_win = w_ls_elig;
                end
                if (w_if_win) begin
                    bus_req_valid = clk_en;
                    bus_req_addr  = if_req_addr;
                    bus_req_mask  = 2'b11;
                    if_req_ready  = clk_en && bus_req_ready;
                end else if (w_ls_win) begin
                    if (ls_req_mode[1]) begin
                        // Fence: consumed locally, never reaches the bus.
                        ls_req_ready = clk_en;
                        w_state_nxt  = w_empty ? S_DONE : S_DRAIN;
                    end else begin
                        bus_req_valid = clk_en;
                        bus_req_write = (ls_req_mode == c_MODE_WRITE);
                        bus_req_addr  = ls_req_addr;
                        bus_req_mask  = ls_req_mask;
                        bus_req_data  = ls_req_data;
                        ls_req_ready  = clk_en && bus_req_ready;
                    end
                end
            end
            S_DRAIN: begin
                if (w_empty) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_ARB;
            end
            default: begin
                w_state_nxt = S_ARB;
            end
        endcase
    end

    // FSM, priority pointer, FIFO pointers/count, response registers, err.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_state      <= S_ARB;
            r_prio       <= c_SRC_IF;
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            ls_rsp_valid <= 1'b0;
            ls_rsp_data  <= '0;
            ls_rsp_tag   <= '0;
            err          <= 1'b0;
        end else if (clk_en) begin
            r_state <= w_state_nxt;
            if (if_req_ready) begin
                r_prio <= c_SRC_LS;
            end else if (ls_req_ready) begin
                r_prio <= c_SRC_IF;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_ONE;
            end
            if_rsp_valid <= w_pop && (w_head_src == c_SRC_IF);
            ls_rsp_valid <= w_pop && (w_head_src == c_SRC_LS);
            if (w_pop && (w_head_src == c_SRC_IF)) begin
                if_rsp_data <= bus_rsp_data;
            end
            if (w_pop && (w_head_src == c_SRC_LS)) begin
                ls_rsp_data <= bus_rsp_data;
                ls_rsp_tag  <= r_fifo_tag[r_rd_ptr];
            end
            if (w_stray) begin
                err <= 1'b1;
            end
        end
    end

    // FIFO storage: source and writeback tag of each transferred read.
    always_ff @(posedge clk) begin
        if (clk_en && w_push) begin
            r_fifo_src[r_wr_ptr] <= w_if_win ? c_SRC_IF : c_SRC_LS;
            r_fifo_tag[r_wr_ptr] <= w_if_win ? '0 : ls_req_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed self-checking bench for mem_port_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        sync_rst;
    logic        clk_en;
    logic        if_req_valid;
    logic [14:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [15:0] if_rsp_data;
    logic        ls_req_valid;
    logic [1:0]  ls_req_mode;
    logic [14:0] ls_req_addr;
    logic [1:0]  ls_req_mask;
    logic [15:0] ls_req_data;
    logic [3:0]  ls_req_tag;
    logic        ls_req_ready;
    logic        ls_rsp_valid;
    logic [15:0] ls_rsp_data;
    logic [3:0]  ls_rsp_tag;
    logic        ls_fence_done;
    logic        bus_req_valid;
    logic        bus_req_write;
    logic [14:0] bus_req_addr;
    logic [1:0]  bus_req_mask;
    logic [15:0] bus_req_data;
    logic        bus_req_ready;
    logic        bus_rsp_valid;
    logic [15:0] bus_rsp_data;
    logic        idle;
    logic        err;

    int n_total = 0;
    int n_pass  = 0;

    mem_port_arbiter #(
        .ADDR_W(15), .DATA_W(16), .TAG_W(4), .MAX_OUTST(4)
    ) dut (
        .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
        .if_req_ready(if_req_ready), .if_rsp_valid(if_rsp_valid),
        .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_mode(ls_req_mode),
        .ls_req_addr(ls_req_addr), .ls_req_mask(ls_req_mask),
        .ls_req_data(ls_req_data), .ls_req_tag(ls_req_tag),
        .ls_req_ready(ls_req_ready), .ls_rsp_valid(ls_rsp_valid),
        .ls_rsp_data(ls_rsp_data), .ls_rsp_tag(ls_rsp_tag),
        .ls_fence_done(ls_fence_done),
        .bus_req_valid(bus_req_valid), .bus_req_write(bus_req_write),
        .bus_req_addr(bus_req_addr), .bus_req_mask(bus_req_mask),
        .bus_req_data(bus_req_data), .bus_req_ready(bus_req_ready),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data),
        .idle(idle), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance to the next cycle: inputs change right after the falling edge.
    task automatic nxt();
        @(negedge clk);
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    task automatic quiet();
        if_req_valid  = 1'b0;
        ls_req_valid  = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rsp_data  = 16'h0;
    endtask

    initial begin
        sync_rst      = 1'b1;
        clk_en        = 1'b1;
        if_req_valid  = 1'b0;
        if_req_addr   = '0;
        ls_req_valid  = 1'b0;
        ls_req_mode   = 2'd0;
        ls_req_addr   = '0;
        ls_req_mask   = 2'b00;
        ls_req_data   = '0;
        ls_req_tag    = '0;
        bus_req_ready = 1'b1;
        bus_rsp_valid = 1'b0;
        bus_rsp_data  = '0;
        repeat (2) nxt();
        sync_rst = 1'b0;
        settle();
        chk("rst_idle", idle, 1);
        chk("rst_err", err, 0);
        chk("rst_if_rdy", if_req_ready, 0);
        chk("rst_ls_rdy", ls_req_ready, 0);
        chk("rst_bus_v", bus_req_valid, 0);
        chk("rst_if_rsp", if_rsp_valid, 0);
        chk("rst_ls_rsp", ls_rsp_valid, 0);
        chk("rst_fdone", ls_fence_done, 0);

        // ---------------- round robin, then FIFO full -----------------
        nxt();
        if_req_valid = 1; if_req_addr = 15'h100;
        ls_req_valid = 1; ls_req_mode = 2'd0; ls_req_addr = 15'h200; ls_req_tag = 4'd5;
        ls_req_mask = 2'b11;
        settle();
        chk("rr1_addr", bus_req_addr, 15'h100);
        chk("rr1_if_rdy", if_req_ready, 1);
        chk("rr1_ls_rdy", ls_req_ready, 0);
        chk("rr1_mask", bus_req_mask, 2'b11);
        chk("rr1_wr", bus_req_write, 0);
        nxt(); if_req_addr = 15'h101;
        settle();
        chk("rr2_addr", bus_req_addr, 15'h200);
        chk("rr2_ls_rdy", ls_req_ready, 1);
        chk("rr2_if_rdy", if_req_ready, 0);
        nxt(); ls_req_addr = 15'h201; ls_req_tag = 4'd6;
        settle();
        chk("rr3_addr", bus_req_addr, 15'h101);
        nxt();
        settle();
        chk("rr4_addr", bus_req_addr, 15'h201);
        nxt(); if_req_addr = 15'h102;
        settle();
        chk("full_bus_v", bus_req_valid, 0);
        chk("full_if_rdy", if_req_ready, 0);
        chk("full_idle", idle, 0);
        nxt(); ls_req_mode = 2'd1; ls_req_addr = 15'h0010; ls_req_data = 16'hBEEF; ls_req_mask = 2'b01;
        settle();
        chk("wr_bus_v", bus_req_valid, 1);
        chk("wr_write", bus_req_write, 1);
        chk("wr_addr", bus_req_addr, 15'h0010);
        chk("wr_data", bus_req_data, 16'hBEEF);
        chk("wr_mask", bus_req_mask, 2'b01);
        chk("wr_ls_rdy", ls_req_ready, 1);
        chk("wr_if_rdy", if_req_ready, 0);
        nxt(); ls_req_valid = 0; bus_rsp_valid = 1; bus_rsp_data = 16'hAAAA;
        settle();
        chk("pop_same_cyc_if_rdy", if_req_ready, 0);
        nxt(); bus_rsp_valid = 0;
        settle();
        chk("refill_if_rdy", if_req_ready, 1);
        chk("refill_addr", bus_req_addr, 15'h102);
        chk("rsp1_if_v", if_rsp_valid, 1);
        chk("rsp1_if_d", if_rsp_data, 16'hAAAA);
        nxt(); if_req_valid = 0; bus_rsp_valid = 1; bus_rsp_data = 16'h1111;
        settle();
        chk("nopop_if_v", if_rsp_valid, 0);
        nxt(); bus_rsp_data = 16'h2222;
        settle();
        chk("rsp2_ls_v", ls_rsp_valid, 1);
        chk("rsp2_ls_d", ls_rsp_data, 16'h1111);
        chk("rsp2_ls_tag", ls_rsp_tag, 4'd5);
        chk("rsp2_if_v", if_rsp_valid, 0);
        nxt(); bus_rsp_data = 16'h3333;
        settle();
        chk("rsp3_if_d", if_rsp_data, 16'h2222);
        chk("rsp3_ls_v", ls_rsp_valid, 0);
        nxt(); bus_rsp_data = 16'h4444;
        settle();
        chk("rsp4_ls_d", ls_rsp_data, 16'h3333);
        chk("rsp4_ls_tag", ls_rsp_tag, 4'd6);
        nxt(); bus_rsp_valid = 0;
        settle();
        chk("rsp5_if_d", if_rsp_data, 16'h4444);
        chk("rr_idle", idle, 1);

        // ---------------- backpressure (priority is LS) ----------------
        nxt();
        bus_req_ready = 0;
        if_req_valid = 1; if_req_addr = 15'h180;
        ls_req_valid = 1; ls_req_mode = 2'd0; ls_req_addr = 15'h300; ls_req_tag = 4'd8;
        ls_req_mask = 2'b11;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("bp_ls_rdy", ls_req_ready, 0);
            chk("bp_if_rdy", if_req_ready, 0);
            chk("bp_addr", bus_req_addr, 15'h300);
            chk("bp_bus_v", bus_req_valid, 1);
            nxt();
        end
        bus_req_ready = 1;
        settle();
        chk("bp_go_ls_rdy", ls_req_ready, 1);
        nxt();
        settle();
        chk("bp_then_if_rdy", if_req_ready, 1);
        chk("bp_then_addr", bus_req_addr, 15'h180);

        // ---------------- fence with 3 reads outstanding ---------------
        nxt(); if_req_valid = 0; ls_req_addr = 15'h301; ls_req_tag = 4'd7;
        settle();
        chk("f_pre_ls_rdy", ls_req_ready, 1);
        nxt(); ls_req_mode = 2'd2; bus_req_ready = 0;
        settle();
        chk("f_acc_ls_rdy", ls_req_ready, 1);
        chk("f_acc_bus_v", bus_req_valid, 0);
        nxt(); ls_req_valid = 0; bus_req_ready = 1; if_req_valid = 1; if_req_addr = 15'h190;
        settle();
        chk("f_drain_if_rdy", if_req_ready, 0);
        chk("f_drain_bus_v", bus_req_valid, 0);
        chk("f_drain_idle", idle, 0);
        chk("f_drain_done", ls_fence_done, 0);
        nxt(); bus_rsp_valid = 1; bus_rsp_data = 16'h5555;
        settle();
        chk("f_r1_if_rdy", if_req_ready, 0);
        chk("f_r1_done", ls_fence_done, 0);
        nxt(); bus_rsp_data = 16'h6666;
        settle();
        chk("f_r2_ls_d", ls_rsp_data, 16'h5555);
        chk("f_r2_ls_tag", ls_rsp_tag, 4'd8);
        chk("f_r2_done", ls_fence_done, 0);
        nxt(); bus_rsp_data = 16'h7777;
        settle();
        chk("f_r3_if_v", if_rsp_valid, 1);
        chk("f_r3_if_d", if_rsp_data, 16'h6666);
        chk("f_r3_done", ls_fence_done, 0);
        nxt(); bus_rsp_valid = 0;
        settle();
        chk("f_r4_ls_d", ls_rsp_data, 16'h7777);
        chk("f_r4_ls_tag", ls_rsp_tag, 4'd7);
        chk("f_r4_done", ls_fence_done, 0);
        chk("f_r4_if_rdy", if_req_ready, 0);
        nxt();
        settle();
        chk("f_done_pulse", ls_fence_done, 1);
        chk("f_done_if_rdy", if_req_ready, 0);
        nxt();
        settle();
        chk("f_after_done", ls_fence_done, 0);
        chk("f_resume_if_rdy", if_req_ready, 1);
        chk("f_resume_addr", bus_req_addr, 15'h190);
        nxt(); if_req_valid = 0; bus_rsp_valid = 1; bus_rsp_data = 16'h8888;
        nxt(); bus_rsp_valid = 0;
        settle();
        chk("f_last_if_d", if_rsp_data, 16'h8888);
        chk("f_last_idle", idle, 1);

        // ---------------- stray response ------------------------------
        nxt(); bus_rsp_valid = 1; bus_rsp_data = 16'h9999;
        nxt(); bus_rsp_valid = 0;
        settle();
        chk("stray_if_v", if_rsp_valid, 0);
        chk("stray_ls_v", ls_rsp_valid, 0);
        chk("stray_err", err, 1);
        nxt();
        settle();
        chk("stray_err_sticky", err, 1);
        nxt(); sync_rst = 1;
        nxt(); sync_rst = 0;
        settle();
        chk("stray_rst_err", err, 0);
        chk("stray_rst_idle", idle, 1);

        // ---------------- reset mid-operation, then clk_en=0 ----------
        nxt();
        if_req_valid = 1; if_req_addr = 15'h1A0;
        ls_req_valid = 1; ls_req_mode = 2'd0; ls_req_addr = 15'h3A0; ls_req_tag = 4'd3;
        settle();
        chk("mid_if_rdy", if_req_ready, 1);
        nxt();
        settle();
        chk("mid_ls_rdy", ls_req_ready, 1);
        nxt(); quiet(); sync_rst = 1;
        settle();
        chk("mid_busy", idle, 0);
        nxt(); sync_rst = 0;
        if_req_valid = 1; ls_req_valid = 1;
        settle();
        chk("mid_rst_idle", idle, 1);
        chk("mid_rst_if_rdy", if_req_ready, 1);
        nxt();
        settle();
        chk("mid_rst_ls_rdy", ls_req_ready, 1);
        nxt(); clk_en = 0;
        settle();
        chk("cen_if_rdy", if_req_ready, 0);
        chk("cen_ls_rdy", ls_req_ready, 0);
        chk("cen_bus_v", bus_req_valid, 0);
        nxt();
        settle();
        chk("cen_hold_bus_v", bus_req_valid, 0);
        nxt(); clk_en = 1;
        settle();
        chk("cen_back_if_rdy", if_req_ready, 1);
        chk("cen_back_addr", bus_req_addr, 15'h1A0);
        nxt(); quiet();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single external memory port between two requesters: the instruction-fetch refill path (IF, read-only) and the load/store unit (LS: read, write, fence).
- Arbitrates round-robin and tracks outstanding reads in an in-order FIFO so each bus response is routed back to its source with its writeback tag.
- Executes LS fences locally by draining all outstanding reads. Fences are never forwarded to the bus.

Parameters:
- ADDR_W, 15, address width (halfword address)
- DATA_W, 16, data width
- TAG_W, 4, LS writeback destination tag width
- MAX_OUTST, 4, depth of the outstanding-read FIFO (power of 2, at least 2)

Ports:
- clk  in  1  clock
- sync_rst  in  1  synchronous active-high reset
- clk_en  in  1  global clock enable; gates every state update
- if_req_valid  in  1  IF read request
- if_req_addr  in  ADDR_W  IF read address
- if_req_ready  out  1  IF request accepted this cycle
- if_rsp_valid  out  1  IF read data valid
- if_rsp_data  out  DATA_W  IF read data
- ls_req_valid  in  1  LS request
- ls_req_mode  in  2  0=READ, 1=WRITE, 2/3=FENCE
- ls_req_addr  in  ADDR_W  LS address
- ls_req_mask  in  2  byte mask, bit1 = high byte
- ls_req_data  in  DATA_W  LS write data
- ls_req_tag  in  TAG_W  LS writeback destination
- ls_req_ready  out  1  LS request accepted this cycle
- ls_rsp_valid  out  1  LS read data valid
- ls_rsp_data  out  DATA_W  LS read data
- ls_rsp_tag  out  TAG_W  tag of the returned LS read
- ls_fence_done  out  1  one-cycle pulse when a fence completes
- bus_req_valid  out  1  bus request
- bus_req_write  out  1  1=write, 0=read
- bus_req_addr  out  ADDR_W  bus address
- bus_req_mask  out  2  bus byte mask (2'b11 for IF)
- bus_req_data  out  DATA_W  bus write data
- bus_req_ready  in  1  bus accepts the request
- bus_rsp_valid  in  1  read data returned; in order, no backpressure
- bus_rsp_data  in  DATA_W  read data
- idle  out  1  FSM in ARB and FIFO empty
- err  out  1  sticky: a response arrived with the FIFO empty

Behaviour:
- Reset: all outputs 0 except idle=1. FIFO emptied, FSM=ARB, round-robin priority=IF, err=0. A reset mid-operation discards all tracked reads.
- FSM states:
  - ARB: normal arbitration.
  - DRAIN: an accepted fence is waiting for the FIFO to empty. No grants to either requester.
  - DONE: drives ls_fence_done=1 for one cycle, then returns to ARB.
- Eligibility in ARB:
  - IF is eligible when if_req_valid=1 and the FIFO is not full.
  - An LS READ is eligible when the FIFO is not full.
  - An LS WRITE is always eligible.
  - An LS FENCE is always eligible.
  - A same-cycle pop does not free a slot for that cycle's eligibility.
- Selection:
  - If both requesters are eligible, the priority holder wins.
  - If only one is eligible, it wins.
  - The priority pointer moves to the other requester after any completed grant.
- Bus request path (combinational):
  - bus_req_* is a mux of the winner's fields.
  - bus_req_valid=1 only when the winner is a bus op (read or write) and clk_en=1.
  - The winner's *_req_ready = bus_req_ready. The loser's ready = 0.
  - A request transfers on valid&&ready. A stalled winner keeps the grant; priority does not move.
- Fence path:
  - When LS wins with a FENCE, ls_req_ready=1 regardless of bus_req_ready and bus_req_valid=0.
  - Next state is DRAIN, or DONE directly if the FIFO is already empty.
  - Modes 2 and 3 behave identically.
  - DRAIN moves to DONE on the cycle after the FIFO becomes empty.
- Read tracking:
  - Each transferred read pushes {src, tag} to the FIFO. IF entries carry tag=0.
  - A push and a pop in the same cycle leave the count unchanged.
- Responses:
  - bus_rsp_valid pops the FIFO head.
  - One cycle later (registered), the matching *_rsp_valid pulses with the data, plus ls_rsp_tag for LS.
  - bus_rsp_valid with the FIFO empty: no pop, no rsp pulse, err<=1. err clears only on sync_rst.
- Writes produce no response and no FIFO entry.
- clk_en=0:
  - Every *_req_ready and bus_req_valid is forced to 0.
  - No state update occurs; rsp outputs hold their values.
  - Responses presented while clk_en=0 are lost; the bus must not present them.
- Pointer wrap: the FIFO read and write pointers wrap modulo MAX_OUTST; full/empty is decided by an explicit count, 0..MAX_OUTST.

Test Plan:
- Round-robin: both requesters issue continuous reads, bus_req_ready=1, responses after 2 cycles -> bus addresses alternate IF,LS,IF,LS. Data 0x1111 returned for the LS read tagged 5 -> ls_rsp_valid with ls_rsp_data=0x1111 and ls_rsp_tag=5 one cycle after bus_rsp_valid.
- FIFO full: MAX_OUTST=4, bus_req_ready=1, no responses, 4 IF reads issued -> if_req_ready=0 on the 5th. A pending LS WRITE (addr 0x0010, data 0xBEEF, mask 2'b01) is still granted with bus_req_write=1. One response -> IF is accepted again the following cycle.
- Backpressure: bus_req_ready=0 for 3 cycles while the LS read is the winner -> ls_req_ready=0 and priority unchanged. On the first ready cycle the LS read transfers, then IF wins.
- Fence: 3 reads outstanding, LS FENCE (mode 2) presented -> accepted in 1 cycle, then no grants and idle=0. After the 3rd response, ls_fence_done pulses exactly once, then arbitration resumes.
- Stray response: bus_rsp_valid with the FIFO empty -> no rsp pulse, err=1 and sticky. sync_rst -> err=0, idle=1.
- Reset mid-operation: 2 reads outstanding, sync_rst pulsed -> idle=1 next cycle and both readys usable. Then clk_en=0 with both requesting -> no readys and no bus_req_valid.
